// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch run-control block: FSM state
// encoding and the width helper used to size the counters.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_LAP   = 2'd3;

   // Bits needed to hold values 0 .. value-1 (never less than one bit).
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      if (w == 0) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: two-flop synchroniser, stability counter that
// only accepts a level after DB_CYCLES consecutive differing samples, and a
// registered one-cycle pulse on the accepted rising edge.
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);

   localparam int CW = clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_d;
   logic [CW-1:0] cnt;

   // Bring the asynchronous pad level into the clock domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for DB_CYCLES samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (sync2 == level) begin
         cnt <= '0;
      end else if (cnt == CNT_MAX) begin
         level <= sync2;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Registered pulse on the accepted rising edge; releases are silent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
         press   <= 1'b0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d;
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: debounced start/stop, lap and clear
// buttons drive a four-state FSM that gates the one-second tick, pulses the
// counter clear and holds the display while a lap is shown.
// Build option: define STOPWATCH_LAP_EN to include the lap button path;
// without it the lap input is ignored and LAP is never entered.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int FREQ      = 2000,
   parameter int DB_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   output logic       sec_tick,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic       running,
   output logic [1:0] state
);

   localparam int PW = clog2(FREQ);
   localparam logic [PW-1:0] PRE_MAX = PW'(FREQ - 1);

   logic          ev_ss;
   logic          ev_lap;
   logic          ev_clr;
   logic          do_ss;
   logic          do_lap;
   logic          do_clr;
   logic [1:0]    state_nx;
   logic          clr_go;
   logic          counting;
   logic [PW-1:0] presc;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_ss),
      .press (ev_ss)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_clr),
      .press (ev_clr)
   );

`ifdef STOPWATCH_LAP_EN
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_lap),
      .press (ev_lap)
   );
`else
   logic unused_lap;
   assign unused_lap = btn_lap;
   assign ev_lap     = 1'b0;
`endif

   // Keep only the highest-priority event of the cycle: clr > ss > lap.
   always_comb begin
      do_clr = ev_clr;
      do_ss  = ev_ss & ~ev_clr;
      do_lap = ev_lap & ~ev_clr & ~ev_ss;
   end

   // Next-state decode; clr_go marks the transitions that zero the counters.
   always_comb begin
      state_nx = state;
      clr_go   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (do_clr) clr_go = 1'b1;
            else if (do_ss) state_nx = ST_RUN;
         end
         ST_RUN: begin
            if (do_ss) state_nx = ST_PAUSE;
            else if (do_lap) state_nx = ST_LAP;
         end
         ST_LAP: begin
            if (do_lap) state_nx = ST_RUN;
            else if (do_ss) state_nx = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (do_ss) state_nx = ST_RUN;
            else if (do_clr) begin
               state_nx = ST_IDLE;
               clr_go   = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign counting = (state == ST_RUN) || (state == ST_LAP);

   // State register and the registered counter-clear pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt_clr <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt_clr <= clr_go;
      end
   end

   // Seconds prescaler: runs while counting, freezes in PAUSE so the partial
   // second survives, and is held at zero in IDLE and on every clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc    <= '0;
         sec_tick <= 1'b0;
      end else begin
         sec_tick <= counting && (presc == PRE_MAX);
         if (clr_go || state == ST_IDLE) begin
            presc <= '0;
         end else if (counting) begin
            presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
         end
      end
   end

   assign running = counting;

`ifdef STOPWATCH_LAP_EN
   assign disp_hold = (state == ST_LAP);
`else
   assign disp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (FREQ=10, DB_CYCLES=4): directed
// scenarios plus randomized button traffic, all compared every cycle against
// a behavioural model of the stopwatch rules.
module tb_stopwatch_ctrl;

   localparam int FREQ = 10;
   localparam int DB   = 4;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif
   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_LAP   = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_ss = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_clr = 1'b0;
   logic       sec_tick;
   logic       cnt_clr;
   logic       disp_hold;
   logic       running;
   logic [1:0] state;

   stopwatch_ctrl #(.FREQ(FREQ), .DB_CYCLES(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_ss    (btn_ss),
      .btn_lap   (btn_lap),
      .btn_clr   (btn_clr),
      .sec_tick  (sec_tick),
      .cnt_clr   (cnt_clr),
      .disp_hold (disp_hold),
      .running   (running),
      .state     (state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int tick_cnt = 0;
   int clr_cnt = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // Behavioural model: per-button sampled history, accepted level, run
   // length of disagreement, and the stopwatch state with elapsed counts.
   bit sy1[3], sy2[3], acc[3], pend[3], ev[3];
   int diff[3];
   int m_state, m_p;
   bit m_tick, m_clr;

   task automatic model_reset();
      for (int b = 0; b < 3; b++) begin
         sy1[b] = 0; sy2[b] = 0; acc[b] = 0; pend[b] = 0; ev[b] = 0; diff[b] = 0;
      end
      m_state = S_IDLE; m_p = 0; m_tick = 0; m_clr = 0;
   endtask

   task automatic model_step();
      bit raw[3];
      bit rose, counting;
      int pick, nxt;
      raw[0] = btn_ss; raw[1] = btn_lap; raw[2] = btn_clr;
      // event chosen from pulses visible before this edge
      if (ev[2]) pick = 2;
      else if (ev[0]) pick = 0;
      else if (ev[1] && LAP_EN) pick = 1;
      else pick = -1;
      for (int b = 0; b < 3; b++) begin
         rose = 0;
         if (sy2[b] != acc[b]) begin
            diff[b]++;
            if (diff[b] == DB) begin
               acc[b] = sy2[b]; diff[b] = 0; rose = acc[b];
            end
         end else diff[b] = 0;
         ev[b] = pend[b]; pend[b] = rose;
         sy2[b] = sy1[b]; sy1[b] = raw[b];
      end
      counting = (m_state == S_RUN) || (m_state == S_LAP);
      m_tick = counting && (m_p == FREQ - 1);
      m_clr = 0;
      nxt = m_state;
      case (m_state)
         S_IDLE:  if (pick == 2) m_clr = 1; else if (pick == 0) nxt = S_RUN;
         S_RUN:   if (pick == 0) nxt = S_PAUSE; else if (pick == 1) nxt = S_LAP;
         S_LAP:   if (pick == 1) nxt = S_RUN; else if (pick == 0) nxt = S_PAUSE;
         default: if (pick == 0) nxt = S_RUN; else if (pick == 2) begin nxt = S_IDLE; m_clr = 1; end
      endcase
      if (counting) m_p = (m_p + 1) % FREQ;
      if (m_state == S_IDLE || m_clr) m_p = 0;
      m_state = nxt;
   endtask

   // One clock: advance model at the edge, compare 1 ns later.
   task automatic cyc();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      if (sec_tick === 1'b1) tick_cnt++;
      if (cnt_clr === 1'b1) clr_cnt++;
      check("state", state, m_state);
      check("sec_tick", sec_tick, m_tick);
      check("cnt_clr", cnt_clr, m_clr);
      check("running", running, (m_state == S_RUN || m_state == S_LAP));
      check("disp_hold", disp_hold, (m_state == S_LAP));
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim, output int n);
      n = 0;
      while (state !== s && n < lim) begin cyc(); n++; end
   endtask

   task automatic wait_tick(input int lim, output int n);
      n = 0;
      do begin cyc(); n++; end while (sec_tick !== 1'b1 && n < lim);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, state, 0);
      check({tag, "_tick"}, sec_tick, 0);
      check({tag, "_clr"}, cnt_clr, 0);
      check({tag, "_run"}, running, 0);
      check({tag, "_hold"}, disp_hold, 0);
   endtask

   initial begin
      int n, t0, c0;
      model_reset();
      #1 rst = 1'b1;
      #2 check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // idle for 100 cycles
      repeat (100) cyc();
      check("idle_ticks", tick_cnt, 0);
      check("idle_clrs", clr_cnt, 0);

      // start: RUN 8 cycles after the press, ticks every 10
      btn_ss = 1'b1;
      wait_state(2'(S_RUN), 40, n);
      check("ss_latency", n, 8);
      wait_tick(40, n);
      check("first_tick", n, 10);
      btn_ss = 1'b0;
      wait_tick(40, n);
      check("tick_period", n, 10);

      // 3-cycle glitches never register
      for (int g = 0; g < 6; g++) begin
         btn_ss = 1'b1; repeat (3) cyc();
         btn_ss = 1'b0; repeat (3) cyc();
      end
      check("glitch_state", state, S_RUN);

      // pause with 7 counts pending, resume after 50 cycles
      n = 0;
      while (m_p != 9 && n < 40) begin cyc(); n++; end
      btn_ss = 1'b1;
      wait_state(2'(S_PAUSE), 40, n);
      check("pause_latency", n, 8);
      check("pause_presc", 32'(dut.presc), 7);
      btn_ss = 1'b0;
      t0 = tick_cnt;
      repeat (50) cyc();
      check("pause_ticks", tick_cnt - t0, 0);
      btn_ss = 1'b1;
      wait_state(2'(S_RUN), 40, n);
      wait_tick(40, n);
      check("resume_tick", n, 3);
      btn_ss = 1'b0;
      repeat (20) cyc();

      // lap: hold the display, counting continues, second lap releases
      btn_lap = 1'b1;
      repeat (12) cyc();
      btn_lap = 1'b0;
      check("lap_hold", disp_hold, LAP_EN);
      t0 = tick_cnt;
      repeat (30) cyc();
      check("lap_ticks", tick_cnt - t0, 3);
      btn_lap = 1'b1;
      repeat (12) cyc();
      btn_lap = 1'b0;
      check("lap_release", disp_hold, 0);
      check("lap_state", state, S_RUN);
      repeat (10) cyc();

      // PAUSE, then clr and ss together: clr wins
      btn_ss = 1'b1;
      wait_state(2'(S_PAUSE), 40, n);
      btn_ss = 1'b0;
      repeat (20) cyc();
      c0 = clr_cnt;
      btn_ss = 1'b1; btn_clr = 1'b1;
      wait_state(2'(S_IDLE), 40, n);
      check("clr_latency", n, 8);
      check("clr_presc", 32'(dut.presc), 0);
      repeat (5) cyc();
      btn_ss = 1'b0; btn_clr = 1'b0;
      repeat (20) cyc();
      check("clr_pulses", clr_cnt - c0, 1);
      check("clr_state", state, S_IDLE);

      // async reset mid-debounce; held button yields a fresh event afterwards
      btn_ss = 1'b1;
      repeat (6) cyc();
      rst = 1'b1;
      #1 check_all_zero("async_rst");
      repeat (3) cyc();
      rst = 1'b0;
      wait_state(2'(S_RUN), 40, n);
      check("post_rst_latency", n, 8);
      btn_ss = 1'b0;
      repeat (10) cyc();

      // randomized button traffic against the model
      for (int seg = 0; seg < 400; seg++) begin
         btn_ss  = ($urandom % 3) == 0;
         btn_lap = ($urandom % 3) == 0;
         btn_clr = ($urandom % 4) == 0;
         if (($urandom % 60) == 0) begin
            rst = 1'b1; cyc(); rst = 1'b0;
         end
         repeat ($urandom_range(1, 14)) cyc();
      end
      btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
      repeat (20) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
